// File: rtl/imem_load_if.sv
// Byte-stream receive handshake and instruction-memory write port of the program loader.
interface imem_load_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Loads a hex-ASCII program from a UART byte stream into instruction memory, then releases the CPU.
// Define IMEM_LOAD_UPPER_EN to also accept upper-case hex digits A-F.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COLLECT | accepting bytes, assembling a 32-bit word
// WRITE   | one-cycle write strobe of the assembled word
// DONE    | program loaded, CPU running
// ERROR   | malformed input, waiting for start
module imem_load_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [7:0]  TERM_CHAR = 8'h2E
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  imem_load_if.master       bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        nib_q, nib_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        sync_q, sync_d;

  logic       is_dec, is_lc, is_uc, is_hex, is_ws, rx_fire;
  logic [3:0] hex_val;
  logic [ADDR_W:0] wcnt_inc;

  always_comb begin
    is_dec = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_lc  = (bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h66);
`ifdef IMEM_LOAD_UPPER_EN
    is_uc  = (bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h46);
`else
    is_uc  = 1'b0;
`endif
    is_hex  = is_dec | is_lc | is_uc;
    // letters a-f / A-F carry 1..6 in their low nibble
    hex_val = is_dec ? bus.rx_data[3:0] : bus.rx_data[3:0] + 4'd9;
    is_ws   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h0D);
  end

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    word_d   = word_q;
    sync_d   = {sync_q[0], 1'b1};
    rx_fire  = bus.rx_valid && (state_q == S_COLLECT);
    wcnt_inc = wcnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_COLLECT;
          nib_d   = 3'd0;
          addr_d  = '0;
          wcnt_d  = '0;
        end
      end
      S_COLLECT: begin
        if (rx_fire) begin
          if (is_hex) begin
            word_d = {word_q[27:0], hex_val};
            nib_d  = nib_q + 3'd1;
            if (nib_q == 3'd7) state_d = S_WRITE;
          end else if (nib_q != 3'd0) begin
            state_d = S_ERROR;
          end else if (bus.rx_data == TERM_CHAR) begin
            state_d = S_DONE;
          end else if (!is_ws) begin
            state_d = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        wcnt_d  = wcnt_inc;
        nib_d   = 3'd0;
        state_d = (wcnt_inc == DEPTH) ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  // state advances only once the released reset has passed the synchronizer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      nib_q   <= 3'd0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= 32'h0;
    end else if (sync_q[1]) begin
      state_q <= state_d;
      nib_q   <= nib_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
    end
  end

  assign bus.rx_ready   = (state_q == S_COLLECT);
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign cpu_run        = (state_q == S_DONE);
  assign busy           = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign err            = (state_q == S_ERROR);
  assign word_count     = wcnt_q;

endmodule
